// File: rtl/seq_shift_mult_pkg.sv
// Shared definitions for the seq_shift_mult shift-and-add multiplier:
// FSM state encoding, counter width helper and product width helper.
package seq_shift_mult_pkg;

    localparam int X_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int prod_width(input int x);
        return 2 * x;
    endfunction

endpackage

// File: rtl/pre_x_adder.sv
// X-bit carry-lookahead adder: every carry is expanded from generate/propagate
// terms of the lower bits rather than chained from the previous carry signal.
module pre_x_adder #(
    parameter int x = 8
) (
    input  logic [x-1:0] a,
    input  logic [x-1:0] b,
    input  logic         cin,
    output logic [x-1:0] sum,
    output logic         co
);

    logic [x-1:0] w_g;
    logic [x-1:0] w_p;
    logic [x:0]   w_c;
    logic         w_t;

    assign w_g = a & b;
    assign w_p = a ^ b;

    always_comb begin
        w_c    = '0;
        w_t    = 1'b0;
        w_c[0] = cin;
        for (int i = 0; i < x; i++) begin
            w_t = cin;
            for (int j = 0; j <= i; j++) begin
                w_t = w_g[j] | (w_p[j] & w_t);
            end
            w_c[i+1] = w_t;
        end
    end

    assign sum = w_p ^ w_c[x-1:0];
    assign co  = w_c[x];

endmodule

// File: rtl/seq_shift_mult.sv
// Sequential unsigned X-by-X shift-and-add multiplier reusing one pre_x_adder.
// Optional macro ZERO_SKIP_EN: zero operands jump straight from IDLE to DONE.
module seq_shift_mult
    import seq_shift_mult_pkg::*;
#(
    parameter int X = X_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [X-1:0]   a,
    input  logic [X-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*X-1:0] product,
    output logic           busy,
    output logic [1:0]     o_state
);

    localparam int CW = clog2(X);
    localparam int PW = prod_width(X);
    localparam logic [CW-1:0] CNT_LAST = CW'(X - 1);

    state_t          r_state;
    state_t          w_state;
    logic [X-1:0]    r_mcand;
    logic [X-1:0]    w_mcand;
    logic [X-1:0]    r_acc_hi;
    logic [X-1:0]    w_acc_hi;
    logic [X-1:0]    r_acc_lo;
    logic [X-1:0]    w_acc_lo;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt;
    logic [X-1:0]    w_addend;
    logic [X-1:0]    w_sum;
    logic            w_co;
    logic [PW-1:0]   w_shifted;

    assign w_addend = r_acc_lo[0] ? r_mcand : '0;

    pre_x_adder #(.x(X)) u_adder (
        .a   (r_acc_hi),
        .b   (w_addend),
        .cin (1'b0),
        .sum (w_sum),
        .co  (w_co)
    );

    // The carry-out becomes the new MSB, so no partial-sum bit is ever lost.
    assign w_shifted = {w_co, w_sum, r_acc_lo[X-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_mcand  <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state;
            r_mcand  <= w_mcand;
            r_acc_hi <= w_acc_hi;
            r_acc_lo <= w_acc_lo;
            r_cnt    <= w_cnt;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_mcand  = r_mcand;
        w_acc_hi = r_acc_hi;
        w_acc_lo = r_acc_lo;
        w_cnt    = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_mcand  = a;
                    w_acc_hi = '0;
                    w_acc_lo = b;
                    w_cnt    = '0;
                    w_state  = ST_RUN;
`ifdef ZERO_SKIP_EN
                    if (a == '0 || b == '0) begin
                        w_acc_lo = '0;
                        w_state  = ST_DONE;
                    end
`endif
                end
            end
            ST_RUN: begin
                {w_acc_hi, w_acc_lo} = w_shifted;
                // Counter holds at its last value instead of wrapping.
                if (r_cnt == CNT_LAST) begin
                    w_state = ST_DONE;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state = ST_IDLE;
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never drops without a transfer except on rst.
    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state == ST_RUN);
    assign out_valid = (r_state == ST_DONE);
    assign product   = (r_state == ST_DONE) ? {r_acc_hi, r_acc_lo} : '0;
    assign o_state   = r_state;

endmodule

// File: tb/tb_seq_shift_mult.sv
// Self-checking bench for seq_shift_mult: directed and random operand pairs,
// expected products and latencies queued by the driver, checked by a monitor.
module tb_seq_shift_mult;

    localparam int X = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [X-1:0]   a = '0;
    logic [X-1:0]   b = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*X-1:0] product;
    logic           busy;
    logic [1:0]     state_dbg;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int ready_mode = 0;

    logic [2*X-1:0] exp_q[$];
    int             start_q[$];
    int             lat_q[$];

    seq_shift_mult #(.X(X)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy),
        .o_state   (state_dbg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic int model_latency(input logic [X-1:0] op_a, input logic [X-1:0] op_b);
`ifdef ZERO_SKIP_EN
        if (op_a == 0 || op_b == 0) return 1;
`endif
        return X + 1;
    endfunction

    // Called at a falling edge; returns at the falling edge after the transfer
    // with in_valid still high.
    task automatic send(input logic [X-1:0] op_a, input logic [X-1:0] op_b);
        int guard;
        guard = 0;
        in_valid = 1'b1;
        a = op_a;
        b = op_b;
        while (!in_ready) begin
            @(negedge clk);
            guard++;
            if (guard > 200) begin
                check("send_timeout", 32'(in_ready), 32'd1);
                in_valid = 1'b0;
                return;
            end
        end
        check("accept_in_idle", 32'(state_dbg), 32'd0);
        exp_q.push_back((2*X)'(op_a) * (2*X)'(op_b));
        start_q.push_back(cyc);
        lat_q.push_back(model_latency(op_a, op_b));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 || !in_ready) begin
            @(negedge clk);
            guard++;
            if (guard > 300) begin
                check("drain_timeout", 32'(exp_q.size()), 32'd0);
                exp_q.delete();
                start_q.delete();
                lat_q.delete();
                return;
            end
        end
    endtask

    // Monitor: pops expectations when the DUT presents a result.
    logic           prev_valid = 1'b0;
    logic           prev_ready = 1'b0;
    logic [2*X-1:0] prev_prod = '0;

    always begin
        @(negedge clk);
        #1;
        if (rst) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (prev_valid && !prev_ready) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_product", 32'(product), 32'(prev_prod));
            end
            if (prev_valid && prev_ready) begin
                check("release_valid", 32'(out_valid), 32'd0);
                check("release_in_ready", 32'(in_ready), 32'd1);
            end
            if (out_valid) begin
                check("in_ready_low_in_done", 32'(in_ready), 32'd0);
            end
            if (out_valid && !prev_valid) begin
                if (start_q.size() == 0) begin
                    check("unexpected_result", 32'(out_valid), 32'd0);
                end else begin
                    check("latency", 32'(cyc - start_q.pop_front()), 32'(lat_q.pop_front()));
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_product", 32'(out_valid), 32'd0);
                end else begin
                    check("product", 32'(product), 32'(exp_q.pop_front()));
                end
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_prod  = product;
        end
    end

    initial begin
        logic busy_seen;
        int   guard;
        logic [X-1:0] ra;
        logic [X-1:0] rb;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_product", 32'(product), 32'd0);
        check("reset_state", 32'(state_dbg), 32'd0);

        // Basic product and the all-ones carry path.
        ready_mode = 0;
        @(negedge clk);
        send(8'h0A, 8'h03);
        in_valid = 1'b0;
        drain();
        send(8'hFF, 8'hFF);
        in_valid = 1'b0;
        drain();

        // Consumer stalls for several cycles after the result appears.
        ready_mode = 2;
        @(negedge clk);
        @(negedge clk);
        send(8'h12, 8'h34);
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("stall_result_seen", 32'(out_valid), 32'd1);
        repeat (5) @(negedge clk);
        ready_mode = 0;
        drain();

        // Reset in the middle of RUN discards the operation.
        send(8'h55, 8'hAA);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_before_reset", 32'(busy), 32'd1);
        rst = 1'b1;
        exp_q.delete();
        start_q.delete();
        lat_q.delete();
        @(negedge clk);
        rst = 1'b0;
        check("midrun_reset_state", 32'(state_dbg), 32'd0);
        check("midrun_reset_out_valid", 32'(out_valid), 32'd0);
        check("midrun_reset_product", 32'(product), 32'd0);
        check("midrun_reset_busy", 32'(busy), 32'd0);
        send(8'h02, 8'h03);
        in_valid = 1'b0;
        drain();

        // Zero operand: busy is high only on the full RUN path.
        busy_seen = 1'b0;
        send(8'h00, 8'h7F);
        in_valid = 1'b0;
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            busy_seen = busy_seen | busy;
            @(negedge clk);
            guard++;
        end
`ifdef ZERO_SKIP_EN
        check("zero_busy_seen", 32'(busy_seen), 32'd0);
`else
        check("zero_busy_seen", 32'(busy_seen), 32'd1);
`endif
        drain();

        // Back-to-back with in_valid held high.
        send(8'd3, 8'd5);
        send(8'd200, 8'd100);
        send(8'd1, 8'd255);
        in_valid = 1'b0;
        drain();

        // Random operands with random consumer back-pressure.
        ready_mode = 1;
        for (int i = 0; i < 60; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) ra = '0;
            if ($urandom_range(0, 7) == 0) rb = 8'hFF;
            send(ra, rb);
            if ($urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        in_valid = 1'b0;
        ready_mode = 0;
        drain();
        repeat (3) @(negedge clk);
        check("queue_empty_at_end", 32'(exp_q.size()), 32'd0);
        check("end_in_ready", 32'(in_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL global_timeout: got running expected finished at cycle %0d", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "timeout");
    end

endmodule
